// File: rtl/arb_mux_rr.sv
// Round-robin packet arbiter feeding a single registered output beat.
// A channel that starts a packet keeps the grant until its last beat is accepted.
module arb_mux_rr #(
    parameter int InputWidth = 4,
    parameter int DataWidth  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [InputWidth-1:0]           in_valid_i,
    output logic [InputWidth-1:0]           in_ready_o,
    input  logic [InputWidth*DataWidth-1:0] in_data_i,
    input  logic [InputWidth-1:0]           in_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DataWidth-1:0]            out_data_o,
    output logic                            out_last_o,
    output logic [InputWidth-1:0]           out_sel_o
);

    localparam int N = InputWidth;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t          state_q, state_d;
    logic [N-1:0]         ptr_q, ptr_d;
    logic [N-1:0]         lock_sel_q, lock_sel_d;
    logic [N-1:0]         mask_hi, req_hi, grant, xfer_sel;
    logic                 acc, xfer, xfer_last;
    logic [DataWidth-1:0] mux_data;

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    always_comb begin
        mask_hi = ~(ptr_q - N'(1));
        req_hi  = in_valid_i & mask_hi;
        if (state_q == ST_LOCKED) begin
            grant = lock_sel_q & in_valid_i;
        end else if (|req_hi) begin
            grant = req_hi & (~req_hi + N'(1));
        end else begin
            grant = in_valid_i & (~in_valid_i + N'(1));
        end
    end

    assign acc        = ~out_valid_o | out_ready_i;
    assign in_ready_o = grant & {N{acc & ~rst}};
    assign xfer_sel   = in_valid_i & in_ready_o;
    assign xfer       = |xfer_sel;
    assign xfer_last  = |(xfer_sel & in_last_i);

    // xfer_sel is one-hot, so a plain AND-OR picks the payload.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            mux_data = mux_data | (in_data_i[k*DataWidth +: DataWidth] & {DataWidth{xfer_sel[k]}});
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_sel_d = lock_sel_q;
        if (xfer) begin
            if (xfer_last) begin
                state_d = ST_OPEN;
                ptr_d   = (xfer_sel << 1) | (xfer_sel >> (N - 1));
            end else begin
                state_d    = ST_LOCKED;
                lock_sel_d = xfer_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OPEN;
            ptr_q       <= N'(1);
            lock_sel_q  <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_sel_o   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_sel_q <= lock_sel_d;
            if (xfer) begin
                out_valid_o <= 1'b1;
                out_data_o  <= mux_data;
                out_last_o  <= xfer_last;
                out_sel_o   <= xfer_sel;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed vector table plus a randomized scoreboard run for arb_mux_rr (N=4, 8-bit payload).
// Handshake: a beat moves when valid and ready are both high at a rising edge; valid never waits on ready.
module tb_arb_mux_rr;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_valid_i;
    logic [N-1:0]  in_ready_o;
    logic [N*DW-1:0] in_data_i;
    logic [N-1:0]  in_last_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic [N-1:0]  out_sel_o;

    int checks = 0;
    int errors = 0;

    arb_mux_rr #(.InputWidth(N), .DataWidth(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .out_sel_o  (out_sel_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [N-1:0]  v;
        logic [N-1:0]  l;
        logic [31:0]   d;
        logic          ordy;
        logic [N-1:0]  exp_rdy;
        logic          exp_ov;
        logic [DW-1:0] exp_od;
        logic          exp_ol;
        logic [N-1:0]  exp_sel;
    } vec_t;

    vec_t vecs[20];
    vec_t hv;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic ordy, input logic [3:0] erdy,
                                input logic eov, input logic [7:0] eod, input logic eol,
                                input logic [3:0] esel);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.d = d; t.ordy = ordy;
        t.exp_rdy = erdy; t.exp_ov = eov; t.exp_od = eod; t.exp_ol = eol; t.exp_sel = esel;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // driver: present one vector, check combinational ready, clock it, check registers
    task automatic apply_vec(input vec_t t, input int idx);
        rst         = t.rst;
        in_valid_i  = t.v;
        in_last_i   = t.l;
        in_data_i   = t.d;
        out_ready_i = t.ordy;
        #1;
        check("in_ready", idx, 32'(in_ready_o), 32'(t.exp_rdy));
        @(posedge clk); #1;
        check("out_valid", idx, 32'(out_valid_o), 32'(t.exp_ov));
        check("out_data", idx, 32'(out_data_o), 32'(t.exp_od));
        check("out_last", idx, 32'(out_last_o), 32'(t.exp_ol));
        check("out_sel", idx, 32'(out_sel_o), 32'(t.exp_sel));
    endtask

    // scoreboard state for the random run
    logic [8:0] exp_q[N][$];
    logic       hold[N];
    logic [7:0] cur_d[N];
    logic       cur_l[N];
    logic [5:0] seq[N];
    int         wait_pk[N];
    int         max_wait = 0;
    int         out_pkt_ch = -1;

    task automatic monitor_cycle();
        logic [N-1:0] rdy;
        logic [8:0]   e;
        int           ch;
        int           last_ch;
        rdy = in_ready_o;
        checks++;
        if ($countones(rdy) > 1 || (rdy & ~in_valid_i) != '0) begin
            errors++;
            $display("FAIL ready_onehot: got %b valid %b", rdy, in_valid_i);
        end
        if (out_valid_o && out_ready_i) begin
            ch = -1;
            for (int k = 0; k < N; k++) if (out_sel_o == N'(1 << k)) ch = k;
            checks++;
            if (ch < 0 || exp_q[ch].size() == 0) begin
                errors++;
                $display("FAIL out_beat: sel %b data %0h has no pending beat", out_sel_o, out_data_o);
            end else begin
                e = exp_q[ch].pop_front();
                check("rand_data", ch, 32'(out_data_o), 32'(e[7:0]));
                check("rand_last", ch, 32'(out_last_o), 32'(e[8]));
                if (out_pkt_ch >= 0) check("interleave", ch, 32'(ch), 32'(out_pkt_ch));
                out_pkt_ch = out_last_o ? -1 : ch;
            end
        end
        last_ch = -1;
        for (int k = 0; k < N; k++) begin
            if (hold[k] && rdy[k]) begin
                exp_q[k].push_back({cur_l[k], cur_d[k]});
                hold[k]    = 1'b0;
                wait_pk[k] = 0;
                if (cur_l[k]) last_ch = k;
            end
        end
        if (last_ch >= 0) begin
            for (int k = 0; k < N; k++) begin
                if (k != last_ch && hold[k]) begin
                    wait_pk[k]++;
                    if (wait_pk[k] > max_wait) max_wait = wait_pk[k];
                end
            end
        end
    endtask

    task automatic drive_from_hold();
        for (int k = 0; k < N; k++) begin
            in_valid_i[k]            = hold[k];
            in_last_i[k]             = cur_l[k];
            in_data_i[k*DW +: DW]    = cur_d[k];
        end
    endtask

    initial begin
        rst = 1'b1; in_valid_i = '0; in_last_i = '0; in_data_i = '0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        vecs[0]  = mk(1, 4'hF, 4'hF, 32'h44332211, 1, 4'h0, 0, 8'h00, 0, 4'h0);
        vecs[1]  = mk(0, 4'hF, 4'hF, 32'h44332211, 1, 4'h1, 1, 8'h11, 1, 4'h1);
        vecs[2]  = mk(0, 4'hF, 4'hF, 32'h44332211, 1, 4'h2, 1, 8'h22, 1, 4'h2);
        vecs[3]  = mk(0, 4'hF, 4'hF, 32'h44332211, 1, 4'h4, 1, 8'h33, 1, 4'h4);
        vecs[4]  = mk(0, 4'hF, 4'hF, 32'h44332211, 1, 4'h8, 1, 8'h44, 1, 4'h8);
        vecs[5]  = mk(0, 4'hF, 4'hF, 32'h44332211, 1, 4'h1, 1, 8'h11, 1, 4'h1);
        vecs[6]  = mk(0, 4'h7, 4'h5, 32'h0020B110, 1, 4'h2, 1, 8'hB1, 0, 4'h2);
        vecs[7]  = mk(0, 4'h7, 4'h5, 32'h0020B210, 1, 4'h2, 1, 8'hB2, 0, 4'h2);
        vecs[8]  = mk(0, 4'h7, 4'h7, 32'h0020B310, 1, 4'h2, 1, 8'hB3, 1, 4'h2);
        vecs[9]  = mk(0, 4'h5, 4'h5, 32'h00200010, 1, 4'h4, 1, 8'h20, 1, 4'h4);
        vecs[10] = mk(0, 4'h1, 4'h1, 32'h00200010, 1, 4'h1, 1, 8'h10, 1, 4'h1);
        vecs[11] = mk(0, 4'h4, 4'h4, 32'h00A50000, 1, 4'h4, 1, 8'hA5, 1, 4'h4);
        for (int i = 12; i < 17; i++)
            vecs[i] = mk(0, 4'hF, 4'hF, 32'h44332211, 0, 4'h0, 1, 8'hA5, 1, 4'h4);
        vecs[17] = mk(0, 4'hF, 4'hF, 32'h44332211, 1, 4'h8, 1, 8'h44, 1, 4'h8);
        vecs[18] = mk(0, 4'h0, 4'h0, 32'h44332211, 1, 4'h0, 0, 8'h44, 1, 4'h8);
        vecs[19] = mk(0, 4'h0, 4'h0, 32'h44332211, 0, 4'h0, 0, 8'h44, 1, 4'h8);

        for (int i = 0; i < 20; i++) apply_vec(vecs[i], i);

        // lock on ch2 with a two-cycle valid gap while ch0 waits
        hv = mk(0, 4'h4, 4'h0, 32'h00C10000, 1, 4'h4, 1, 8'hC1, 0, 4'h4); apply_vec(hv, 100);
        hv = mk(0, 4'h1, 4'h1, 32'h00C1000F, 1, 4'h0, 0, 8'hC1, 0, 4'h4); apply_vec(hv, 101);
        hv = mk(0, 4'h1, 4'h1, 32'h00C1000F, 1, 4'h0, 0, 8'hC1, 0, 4'h4); apply_vec(hv, 102);
        hv = mk(0, 4'h5, 4'h5, 32'h00C2000F, 1, 4'h4, 1, 8'hC2, 1, 4'h4); apply_vec(hv, 103);
        hv = mk(0, 4'h1, 4'h1, 32'h00C2000F, 1, 4'h1, 1, 8'h0F, 1, 4'h1); apply_vec(hv, 104);

        // reset in the middle of a ch3 packet drops lock and pointer
        hv = mk(0, 4'h8, 4'h0, 32'hD1000000, 1, 4'h8, 1, 8'hD1, 0, 4'h8); apply_vec(hv, 200);
        hv = mk(1, 4'h9, 4'h0, 32'hD2000001, 1, 4'h0, 0, 8'h00, 0, 4'h0); apply_vec(hv, 201);
        hv = mk(0, 4'h9, 4'h9, 32'hD2000001, 1, 4'h1, 1, 8'h01, 1, 4'h1); apply_vec(hv, 202);
        hv = mk(0, 4'h8, 4'h8, 32'hD2000001, 1, 4'h8, 1, 8'hD2, 1, 4'h8); apply_vec(hv, 203);

        // random traffic against per-channel expected queues
        rst = 1'b1; in_valid_i = '0; out_ready_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            hold[k] = 1'b0; cur_d[k] = '0; cur_l[k] = 1'b0; seq[k] = '0; wait_pk[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!hold[k] && $urandom_range(0, 9) < 6) begin
                    hold[k]  = 1'b1;
                    cur_d[k] = {2'(k), seq[k]};
                    cur_l[k] = ($urandom_range(0, 3) == 0);
                    seq[k]   = seq[k] + 6'd1;
                end
            end
            drive_from_hold();
            out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            monitor_cycle();
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) hold[k] = 1'b0;
        drive_from_hold();
        out_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            monitor_cycle();
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) check("drain_empty", k, 32'(exp_q[k].size()), 32'd0);
        checks++;
        if (max_wait > N) begin
            errors++;
            $display("FAIL starvation: waited %0d packets, limit %0d", max_wait, N);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux_rr.md
ARB_MUX_RR -- requirements
Module: arb_mux_rr

Interface
REQ-001 Parameter InputWidth, default 4, number of requesting channels N (N >= 1) SHALL be supported.
REQ-002 Parameter DataWidth, default 8, payload bits per channel SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset SHALL be synchronous and active-high.
REQ-005 in_valid_i  input  N  per-channel beat valid.
REQ-006 in_ready_o  output  N  per-channel beat accepted this cycle when paired with valid.
REQ-007 in_data_i  input  N*DataWidth  channel k payload at bits [k*DataWidth +: DataWidth].
REQ-008 in_last_i  input  N  per-channel end-of-packet marker.
REQ-009 out_valid_o  output  1  registered output beat valid.
REQ-010 out_ready_i  input  1  downstream accept.
REQ-011 out_data_o  output  DataWidth  registered payload.
REQ-012 out_last_o  output  1  registered last marker.
REQ-013 out_sel_o  output  N  one-hot source channel of the registered beat.

Function
REQ-014 Output stage: single register entry; accept enable acc = ~out_valid_o | out_ready_i.
REQ-015 Priority pointer ptr: one-hot, N bits; grant = first asserted in_valid_i at index >= idx(ptr), wrapping from N-1 to 0.
REQ-016 Lock: after an accepted beat with in_last_i=0 from channel k, grant SHALL be forced to channel k only (other valids ignored) until a beat with in_last_i=1 from k is accepted.
REQ-017 While locked and in_valid_i[k]=0, no channel SHALL be granted (bubble), lock held.
REQ-018 in_ready_o[k] = grant[k] & acc, combinational; at most one in_ready_o bit high per cycle.
REQ-019 Transfer on channel k when in_valid_i[k] & in_ready_o[k]: next cycle out_valid_o=1, out_data_o=channel k data, out_last_o=in_last_i[k], out_sel_o=one-hot k; latency exactly 1 cycle.
REQ-020 Payload selection SHALL be one-hot AND-OR over channels (no priority encoder on data path).
REQ-021 If out_valid_o & out_ready_i and no transfer this cycle, out_valid_o SHALL drop to 0; out_data_o/out_last_o/out_sel_o hold last values.
REQ-022 If out_valid_o & ~out_ready_i, all output registers SHALL hold; no input accepted.
REQ-023 Simultaneous output drain and new transfer SHALL sustain 1 beat/cycle throughput.
REQ-024 ptr update: on accepted beat with in_last_i=1 from channel k, ptr = one-hot (k+1) mod N; otherwise ptr unchanged.
REQ-025 N=1: channel 0 always granted when acc; ptr fixed at 1'b1.
REQ-026 in_valid_i SHALL NOT depend on in_ready_o; in_ready_o MAY depend on in_valid_i.

Reset
REQ-027 While rst=1 at a clock edge: out_valid_o=0, out_data_o=0, out_last_o=0, out_sel_o=0, ptr=one-hot index 0, lock cleared.
REQ-028 While rst=1, in_ready_o SHALL be all zero; any beat presented is not accepted.
REQ-029 Reset mid-packet SHALL discard the lock and any held output beat; first post-reset grant follows REQ-015 from index 0.

Verification (N=4, DataWidth=8)
REQ-030 All four valid, all last=1, out_ready_i=1 continuously -> out_sel_o sequence 0001,0010,0100,1000,0001; one beat per cycle, data matches source.
REQ-031 Ch1 sends 3-beat packet (last on beat 3) while ch0/ch2 valid -> three consecutive ch1 beats on output, then ch2 granted (ptr=0100), then ch3 skipped if idle, then ch0.
REQ-032 Output beat 0xA5 held with out_ready_i=0 for 5 cycles -> out_data_o=0xA5, out_valid_o=1 stable, in_ready_o=0000 throughout; release -> next beat follows next cycle.
REQ-033 Locked on ch2 (last=0 accepted), ch2 valid drops for 2 cycles while ch0 valid -> no output beats those cycles, ch0 in_ready_o=0; ch2 resumes and completes first.
REQ-034 rst asserted one cycle during a locked packet on ch3 -> next cycle all outputs zero, in_ready_o=0000; after rst, ch0 and ch3 valid -> ch0 granted first.
REQ-035 Random valid/last/out_ready_i, 10k cycles -> scoreboard: no lost/duplicated beats, per-channel order preserved, packets never interleaved, no channel starved longer than N packets.
